// File: rtl/lock_controller_pkg.sv
// Shared types and constants for the digital-lock sequencer: state encoding,
// failure counter sizing and a constant-foldable clog2.
package lock_controller_pkg;

  localparam int                FAIL_W   = 4;
  localparam logic [FAIL_W-1:0] FAIL_MAX = 4'd15;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    ERROR    = 3'd3,
    UNLOCKED = 3'd4,
    SET_CODE = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/key_digit_encoder.sv
// Turns a key-edge vector into a digit index, flagged valid only when exactly
// one key fired in the cycle.
module key_digit_encoder #(
  parameter int WIDTH     = 4,
  parameter int ENC_WIDTH = 2
) (
  input  logic [WIDTH-1:0]     key_edge,
  output logic [ENC_WIDTH-1:0] digit,
  output logic                 valid
);

  // A power-of-two test: clearing the lowest set bit leaves zero only for one-hot.
  assign valid = (key_edge != '0) && ((key_edge & (key_edge - WIDTH'(1))) == '0);

  // NOTE: digit is given a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    digit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (key_edge[i]) digit = ENC_WIDTH'(i);
    end
  end

endmodule

// File: rtl/lock_sequence_controller.sv
// Digital-lock sequencer: collects key digits, compares them against the stored
// passcode, and handles unlock, relock, code change, timeouts and error lockout.
module lock_sequence_controller
  import lock_controller_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ENC_WIDTH      = 2,
  parameter int CODE_LENGTH    = 4,
  parameter logic [CODE_LENGTH*ENC_WIDTH-1:0] DEFAULT_CODE = 8'b11_10_01_00,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ERROR_CYCLES   = 50
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [WIDTH-1:0]                   keyEdge,
  input  logic                               lockEdge,
  input  logic                               setEdge,
  output logic                               locked,
  output logic                               unlocked,
  output logic                               error,
  output logic                               setMode,
  output logic [clog2(CODE_LENGTH+1)-1:0]    entryCount,
  output logic [FAIL_W-1:0]                  failCount
);

  localparam int CODE_W  = CODE_LENGTH * ENC_WIDTH;
  localparam int CNT_W   = clog2(CODE_LENGTH + 1);
  localparam int TMR_MAX = (TIMEOUT_CYCLES > ERROR_CYCLES) ? TIMEOUT_CYCLES : ERROR_CYCLES;
  localparam int TMR_W   = clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CODE_W-1:0]   buf_ins;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ENC_WIDTH-1:0] digit;
  logic                key_valid;

  key_digit_encoder #(
    .WIDTH     (WIDTH),
    .ENC_WIDTH (ENC_WIDTH)
  ) u_encoder (
    .key_edge (keyEdge),
    .digit    (digit),
    .valid    (key_valid)
  );

  // Buffer with the incoming digit placed in the slot given by the entry count.
  always_comb begin
    buf_ins = buf_q;
    for (int i = 0; i < CODE_LENGTH; i++) begin
      if (cnt_q == CNT_W'(i)) buf_ins[i*ENC_WIDTH +: ENC_WIDTH] = digit;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;

    unique case (state_q)
      LOCKED: begin
        if (key_valid) begin
          buf_d   = buf_ins;
          cnt_d   = CNT_W'(1);
          state_d = ENTRY;
        end
      end
      ENTRY, SET_CODE: begin
        if (lockEdge) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = LOCKED;
        end else if (key_valid) begin
          timer_d = '0;
          if (cnt_q != CNT_W'(CODE_LENGTH - 1)) begin
            buf_d = buf_ins;
            cnt_d = cnt_q + 1'b1;
          end else if (state_q == ENTRY) begin
            buf_d   = buf_ins;
            cnt_d   = cnt_q + 1'b1;
            state_d = CHECK;
          end else begin
            code_d  = buf_ins;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = UNLOCKED;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          buf_d = '0;
          cnt_d = '0;
          if (state_q == ENTRY) state_d = LOCKED;
          else                  state_d = UNLOCKED;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = '0;
          state_d = UNLOCKED;
        end else begin
          if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
          state_d = ERROR;
        end
      end
      ERROR: begin
        if (timer_q == TMR_W'(ERROR_CYCLES - 1)) state_d = LOCKED;
        else                                     timer_d = timer_q + 1'b1;
      end
      UNLOCKED: begin
        if (lockEdge) begin
          state_d = LOCKED;
        end else if (setEdge) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = SET_CODE;
        end
      end
      default: state_d = LOCKED;
    endcase

    // One shared timer serves both the idle timeout and the error hold.
    if (state_d != state_q) timer_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the passcode register is reset like any other flop so a reset restores DEFAULT_CODE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOCKED;
      code_q  <= DEFAULT_CODE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  assign locked     = (state_q == LOCKED) || (state_q == ENTRY) ||
                      (state_q == CHECK)  || (state_q == ERROR);
  assign unlocked   = (state_q == UNLOCKED) || (state_q == SET_CODE);
  assign error      = (state_q == ERROR);
  assign setMode    = (state_q == SET_CODE);
  assign entryCount = cnt_q;
  assign failCount  = fail_q;

endmodule
